// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Merges the ALU and LSB result streams onto one registered common data bus.
//   Each source is buffered in its own FIFO_DEPTH-entry FIFO; a round-robin
//   scheduler drains at most one entry per cycle onto the CDB. The ROB
//   rollback (flush) clears both FIFOs and the bus.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   flush               ROB rollback, synchronous clear (same effect as rst)
//   alu_valid/ready     ALU result handshake (ready is combinational)
//   alu_rob_id/value    ALU result alias and value
//   alu_jump_res/pc     ALU branch-taken flag and target
//   lsb_valid/ready     LSB result handshake (ready is combinational)
//   lsb_rob_id/value    LSB result alias and load data
//   cdb_valid           one-cycle pulse per broadcast entry
//   cdb_src             0 = ALU, 1 = LSB
//   cdb_rob_id/value    broadcast alias and value
//   cdb_jump_res/pc     broadcast branch info (forced to 0 for LSB entries)
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ROBID_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [ROBID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]  alu_value,
    input  logic               alu_jump_res,
    input  logic [DATA_W-1:0]  alu_jump_pc,
    input  logic               lsb_valid,
    output logic               lsb_ready,
    input  logic [ROBID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]  lsb_value,
    output logic               cdb_valid,
    output logic               cdb_src,
    output logic [ROBID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]  cdb_value,
    output logic               cdb_jump_res,
    output logic [DATA_W-1:0]  cdb_jump_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // FIFO storage; contents need no reset because counts gate every read
    logic [ROBID_W-1:0] alu_id_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0]  alu_val_mem [FIFO_DEPTH];
    logic               alu_jr_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0]  alu_pc_mem  [FIFO_DEPTH];
    logic [ROBID_W-1:0] lsb_id_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0]  lsb_val_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr, lsb_wr_ptr, lsb_rd_ptr;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    src_e             last_grant;

    logic active;
    logic alu_push, lsb_push;
    logic alu_nonempty, lsb_nonempty;
    logic grant_alu, grant_lsb;

    assign active    = ~rst & ~flush & rdy;
    assign alu_ready = active & (alu_cnt != FULL_CNT);
    assign lsb_ready = active & (lsb_cnt != FULL_CNT);
    assign alu_push  = alu_valid & alu_ready;
    assign lsb_push  = lsb_valid & lsb_ready;

    assign alu_nonempty = (alu_cnt != '0);
    assign lsb_nonempty = (lsb_cnt != '0);

    // Round-robin: when both sources hold entries, serve the one not granted last
    assign grant_alu = active & alu_nonempty & (~lsb_nonempty | (last_grant == SRC_LSB));
    assign grant_lsb = active & lsb_nonempty & ~grant_alu;

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_id_mem[alu_wr_ptr]  <= alu_rob_id;
            alu_val_mem[alu_wr_ptr] <= alu_value;
            alu_jr_mem[alu_wr_ptr]  <= alu_jump_res;
            alu_pc_mem[alu_wr_ptr]  <= alu_jump_pc;
        end
        if (lsb_push) begin
            lsb_id_mem[lsb_wr_ptr]  <= lsb_rob_id;
            lsb_val_mem[lsb_wr_ptr] <= lsb_value;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_cnt    <= '0;
        end else if (rdy) begin
            if (alu_push)  alu_wr_ptr <= alu_wr_ptr + 1'b1;
            if (grant_alu) alu_rd_ptr <= alu_rd_ptr + 1'b1;
            if (lsb_push)  lsb_wr_ptr <= lsb_wr_ptr + 1'b1;
            if (grant_lsb) lsb_rd_ptr <= lsb_rd_ptr + 1'b1;
            alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(grant_alu);
            lsb_cnt <= lsb_cnt + CNT_W'(lsb_push) - CNT_W'(grant_lsb);
        end
    end

    // Registered bus; data holds on idle cycles so only cdb_valid drops
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid    <= 1'b0;
            cdb_src      <= SRC_ALU;
            cdb_rob_id   <= '0;
            cdb_value    <= '0;
            cdb_jump_res <= 1'b0;
            cdb_jump_pc  <= '0;
            last_grant   <= SRC_LSB;
        end else if (rdy) begin
            if (grant_alu) begin
                cdb_valid    <= 1'b1;
                cdb_src      <= SRC_ALU;
                cdb_rob_id   <= alu_id_mem[alu_rd_ptr];
                cdb_value    <= alu_val_mem[alu_rd_ptr];
                cdb_jump_res <= alu_jr_mem[alu_rd_ptr];
                cdb_jump_pc  <= alu_pc_mem[alu_rd_ptr];
                last_grant   <= SRC_ALU;
            end else if (grant_lsb) begin
                cdb_valid    <= 1'b1;
                cdb_src      <= SRC_LSB;
                cdb_rob_id   <= lsb_id_mem[lsb_rd_ptr];
                cdb_value    <= lsb_val_mem[lsb_rd_ptr];
                cdb_jump_res <= 1'b0;
                cdb_jump_pc  <= '0;
                last_grant   <= SRC_LSB;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Table-driven bench for cdb_arbiter: each row is one clock cycle of inputs
//   with the hand-computed ready values (before the edge) and the CDB contents
//   (after the edge). Data values are derived from the alias so that value,
//   jump flag and jump target are all checked per broadcast.
module tb_cdb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ROBID_W    = 4;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst, rdy, flush;
    logic               alu_valid, alu_ready, alu_jump_res;
    logic [ROBID_W-1:0] alu_rob_id;
    logic [DATA_W-1:0]  alu_value, alu_jump_pc;
    logic               lsb_valid, lsb_ready;
    logic [ROBID_W-1:0] lsb_rob_id;
    logic [DATA_W-1:0]  lsb_value;
    logic               cdb_valid, cdb_src, cdb_jump_res;
    logic [ROBID_W-1:0] cdb_rob_id;
    logic [DATA_W-1:0]  cdb_value, cdb_jump_pc;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .DATA_W    (DATA_W),
        .ROBID_W   (ROBID_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .flush       (flush),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rob_id  (alu_rob_id),
        .alu_value   (alu_value),
        .alu_jump_res(alu_jump_res),
        .alu_jump_pc (alu_jump_pc),
        .lsb_valid   (lsb_valid),
        .lsb_ready   (lsb_ready),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .cdb_jump_res(cdb_jump_res),
        .cdb_jump_pc (cdb_jump_pc)
    );

    typedef struct {
        logic       rst;
        logic       flush;
        logic       rdy;
        logic       av;
        logic [3:0] aid;
        logic       lv;
        logic [3:0] lid;
        logic       exp_ar;
        logic       exp_lr;
        logic       exp_v;
        logic       exp_src;
        logic [3:0] exp_id;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] alu_val_of(input logic [3:0] id);
        return 32'hA000_0000 | {28'h0, id};
    endfunction

    function automatic logic [31:0] alu_pc_of(input logic [3:0] id);
        return 32'h0000_1000 + {26'h0, id, 2'b00};
    endfunction

    function automatic logic [31:0] lsb_val_of(input logic [3:0] id);
        return 32'hB000_0000 | {28'h0, id};
    endfunction

    function automatic vec_t mk(input int r, input int f, input int rd, input int av, input int aid,
                                input int lv, input int lid, input int ar, input int lr,
                                input int ev, input int es, input int eid);
        vec_t t;
        t.rst     = 1'(r);
        t.flush   = 1'(f);
        t.rdy     = 1'(rd);
        t.av      = 1'(av);
        t.aid     = 4'(aid);
        t.lv      = 1'(lv);
        t.lid     = 4'(lid);
        t.exp_ar  = 1'(ar);
        t.exp_lr  = 1'(lr);
        t.exp_v   = 1'(ev);
        t.exp_src = 1'(es);
        t.exp_id  = 4'(eid);
        return t;
    endfunction

    task automatic checkOutput(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic rd, input logic av, input logic [3:0] aid,
                         input logic lv, input logic [3:0] lid);
        rst          = r;
        flush        = f;
        rdy          = rd;
        alu_valid    = av;
        alu_rob_id   = aid;
        alu_value    = alu_val_of(aid);
        alu_jump_res = aid[0];
        alu_jump_pc  = alu_pc_of(aid);
        lsb_valid    = lv;
        lsb_rob_id   = lid;
        lsb_value    = lsb_val_of(lid);
    endtask

    // One table row: drive, check ready before the edge, check the bus after it
    task automatic applyStimulus(input vec_t t, input int row);
        drive(t.rst, t.flush, t.rdy, t.av, t.aid, t.lv, t.lid);
        #1;
        checkOutput("alu_ready", row, 64'(alu_ready), 64'(t.exp_ar));
        checkOutput("lsb_ready", row, 64'(lsb_ready), 64'(t.exp_lr));
        @(posedge clk);
        #1;
        checkOutput("cdb_valid", row, 64'(cdb_valid), 64'(t.exp_v));
        if (t.exp_v) begin
            checkOutput("cdb_src", row, 64'(cdb_src), 64'(t.exp_src));
            checkOutput("cdb_rob_id", row, 64'(cdb_rob_id), 64'(t.exp_id));
            if (t.exp_src == 1'b0) begin
                checkOutput("cdb_value", row, 64'(cdb_value), 64'(alu_val_of(t.exp_id)));
                checkOutput("cdb_jump_res", row, 64'(cdb_jump_res), 64'(t.exp_id[0]));
                checkOutput("cdb_jump_pc", row, 64'(cdb_jump_pc), 64'(alu_pc_of(t.exp_id)));
            end else begin
                checkOutput("cdb_value", row, 64'(cdb_value), 64'(lsb_val_of(t.exp_id)));
                checkOutput("cdb_jump_res", row, 64'(cdb_jump_res), 64'(0));
                checkOutput("cdb_jump_pc", row, 64'(cdb_jump_pc), 64'(0));
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        @(posedge clk);
        #1;

        //        rst fl rdy av aid lv lid  ar lr  v src id
        // reset with an offered input that must be dropped, then single ALU push
        tbl.push_back(mk(1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // reset, then simultaneous ALU/LSB push: ALU first, LSB next
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // streaming ALU ids 1..6, ready stays high
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1, 4, 0, 0, 1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 1, 5, 0, 0, 1, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 1, 6, 0, 0, 1, 1, 1, 0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // both sources pushing every cycle until full, then alternating drain
        tbl.push_back(mk(0, 0, 1, 1, 7, 1, 11, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8, 1, 12, 1, 1, 1, 1, 11));
        tbl.push_back(mk(0, 0, 1, 1, 9, 1, 13, 1, 1, 1, 0, 7));
        tbl.push_back(mk(0, 0, 1, 1, 10, 1, 14, 1, 1, 1, 1, 12));
        tbl.push_back(mk(0, 0, 1, 1, 11, 1, 15, 1, 1, 1, 0, 8));
        tbl.push_back(mk(0, 0, 1, 1, 12, 1, 1, 1, 1, 1, 1, 13));
        tbl.push_back(mk(0, 0, 1, 1, 13, 1, 2, 0, 1, 1, 0, 9));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 14));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 10));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 15));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 11));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 12));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // flush with three entries queued while the bus is valid
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4, 1, 5, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 1, 1, 1, 6, 1, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        // rdy low for three cycles: bus frozen, drain resumes in order
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 1, 4, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 5, 1, 6, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 5, 1, 6, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 5, 1, 6, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        foreach (tbl[i]) applyStimulus(tbl[i], i);

        // reset clears the held bus data (last broadcast was an LSB entry)
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_valid", 100, 64'(cdb_valid), 64'(0));
        checkOutput("rst_src", 100, 64'(cdb_src), 64'(0));
        checkOutput("rst_rob_id", 100, 64'(cdb_rob_id), 64'(0));
        checkOutput("rst_value", 100, 64'(cdb_value), 64'(0));
        checkOutput("rst_jump_res", 100, 64'(cdb_jump_res), 64'(0));
        checkOutput("rst_jump_pc", 100, 64'(cdb_jump_pc), 64'(0));

        // flush takes priority over rdy low and drops the queued entry
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("prio_push_valid", 101, 64'(cdb_valid), 64'(0));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("prio_bcast_valid", 102, 64'(cdb_valid), 64'(1));
        checkOutput("prio_bcast_id", 102, 64'(cdb_rob_id), 64'(6));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        #1;
        checkOutput("prio_alu_ready", 103, 64'(alu_ready), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("prio_flush_valid", 103, 64'(cdb_valid), 64'(0));
        checkOutput("prio_flush_id", 103, 64'(cdb_rob_id), 64'(0));
        checkOutput("prio_flush_value", 103, 64'(cdb_value), 64'(0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("prio_after_valid", 104, 64'(cdb_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
